dsp_vec: RTL and testbench

Parametrised vector DSP engine that replaces the fixed 8-lane, 32-bit DSP unit. It runs element-wise add/sub/mul, a causal FIR convolution, and a dot product over N-lane operand vectors. Optional signed saturation is available on every result. It sits behind the core's coprocessor interface and uses a start/busy/done handshake with one shared multiplier datapath.

---
 rtl/dsp_vec.sv | 101 ++++++++++
 tb/tb_dsp_vec.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dsp_vec.sv
// dsp_vec: N-lane vector add/sub/mul, causal FIR and dot product on one shared multiplier, with optional signed saturation.
module dsp_vec #(
  parameter int W = 32,
  parameter int N = 8,
  parameter int T = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic           sat_en,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  output logic [N*W-1:0] result,
  output logic           busy,
  output logic           done
);
  localparam int AW = 2*W + $clog2(N);
  localparam int NB = $clog2(N);
  localparam int KB = T > 1 ? $clog2(T) : 1;
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
  localparam logic signed [AW-1:0] MX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MN = ~MX;
  logic [1:0] state;
  logic [N*W-1:0] ra, rb, sbuf, nbuf;
  logic [2:0] rop;
  logic rsat;
  logic [NB-1:0] n, j, wl;
  logic [KB-1:0] k;
  logic signed [AW-1:0] acc, sum, pe, ax, bx, lane;
  logic signed [W-1:0] xa, xb, ma, mb, conv;
  logic signed [2*W-1:0] prod;
  logic fir, dot, ill, zero, kend, last, wr;
  always_comb begin
    fir = rop == 3'b010;
    dot = rop == 3'b100;
    ill = rop > 3'b100;
    kend = k == KB'(T-1);
    xa = ra[n*W +: W];
    xb = rb[n*W +: W];
    j = n - NB'(k);
    zero = fir && (NB'(k) > n);
    ma = fir ? ra[k*W +: W] : xa;
    mb = fir ? rb[j*W +: W] : xb;
    prod = ma * mb;
    pe = AW'(prod);
    ax = AW'(xa);
    bx = AW'(xb);
    sum = acc + (zero ? '0 : pe);
    lane = rop == 3'b000 ? ax + bx : rop == 3'b011 ? ax - bx : rop == 3'b001 ? pe : sum;
    conv = !rsat ? lane[W-1:0] : lane > MX ? MX[W-1:0] : lane < MN ? MN[W-1:0] : lane[W-1:0];
    last = ill || (n == NB'(N-1) && (!fir || kend));
    wr = !ill && (!fir || kend) && (!dot || last);
    wl = dot ? '0 : n;
    nbuf = sbuf;
    if (wr) nbuf[wl*W +: W] = conv;
  end
  // result only moves on the EXEC->DONE edge, so partial lanes never show
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      rop <= '0;
      rsat <= 1'b0;
      n <= '0;
      k <= '0;
      acc <= '0;
      sbuf <= '0;
      result <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        ra <= a;
        rb <= b;
        rop <= op;
        rsat <= sat_en;
        n <= '0;
        k <= '0;
        acc <= '0;
        sbuf <= '0;
        state <= EXEC;
      end
    end else if (state == EXEC) begin
      sbuf <= nbuf;
      if (last) begin
        result <= nbuf;
        state <= DONE;
      end
      if (fir && !kend) begin
        k <= k + 1'b1;
        acc <= sum;
      end else begin
        k <= '0;
        acc <= fir ? '0 : sum;
        n <= n + 1'b1;
      end
    end else state <= IDLE;
  end
  assign busy = state == EXEC;
  assign done = state == DONE;
endmodule

// File: tb/tb_dsp_vec.sv
// tb_dsp_vec: directed checks of dsp_vec at W=32 and W=16 (N=8, T=4).
module tb_dsp_vec;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic s1 = 0, s2 = 0, se1 = 0, se2 = 0;
  logic [2:0] op1 = 0, op2 = 0;
  logic [255:0] a1 = 0, b1 = 0, r1, e1;
  logic [127:0] a2 = 0, b2 = 0, r2, e2;
  logic by1, dn1, by2, dn2;
  int cmp = 0, bad = 0;

  dsp_vec #(.W(32), .N(8), .T(4)) u1 (.clk(clk), .rst(rst), .start(s1), .op(op1), .sat_en(se1),
    .a(a1), .b(b1), .result(r1), .busy(by1), .done(dn1));
  dsp_vec #(.W(16), .N(8), .T(4)) u2 (.clk(clk), .rst(rst), .start(s2), .op(op2), .sat_en(se2),
    .a(a2), .b(b2), .result(r2), .busy(by2), .done(dn2));

  task automatic go(input bit w, output int lat);
    @(negedge clk);
    if (w) s2 = 1; else s1 = 1;
    @(negedge clk);
    s1 = 0; s2 = 0; lat = 1;
    while (!(w ? dn2 : dn1) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    cmp++; if (r1 !== 0) begin bad++; $display("FAIL reset_result got=%h want=0", r1); end
    cmp++; if (by1 !== 0 || by2 !== 0) begin bad++; $display("FAIL reset_busy got=%b%b want=00", by1, by2); end
    cmp++; if (dn1 !== 0 || dn2 !== 0) begin bad++; $display("FAIL reset_done got=%b%b want=00", dn1, dn2); end
    rst = 0;
  endtask

  task automatic test_add_sub;
    int lat;
    for (int i = 0; i < 8; i++) begin
      a1[i*32 +: 32] = i + 1;
      b1[i*32 +: 32] = 10 * (i + 1);
      e1[i*32 +: 32] = 11 * (i + 1);
    end
    op1 = 3'b000; se1 = 0;
    go(0, lat);
    cmp++; if (lat !== 9) begin bad++; $display("FAIL add_latency got=%0d want=9", lat); end
    cmp++; if (r1 !== e1) begin bad++; $display("FAIL add_result got=%h want=%h", r1, e1); end
    for (int i = 0; i < 8; i++) e1[i*32 +: 32] = -9 * (i + 1);
    op1 = 3'b011;
    go(0, lat);
    cmp++; if (lat !== 9) begin bad++; $display("FAIL sub_latency got=%0d want=9", lat); end
    cmp++; if (r1 !== e1) begin bad++; $display("FAIL sub_result got=%h want=%h", r1, e1); end
  endtask

  task automatic test_sat;
    int lat;
    for (int i = 0; i < 8; i++) begin
      a2[i*16 +: 16] = 16'h7FFF;
      b2[i*16 +: 16] = 16'h0001;
    end
    op2 = 3'b000; se2 = 1;
    go(1, lat);
    cmp++; if (r2 !== {8{16'h7FFF}}) begin bad++; $display("FAIL sat_add got=%h want=%h", r2, {8{16'h7FFF}}); end
    se2 = 0;
    go(1, lat);
    cmp++; if (r2 !== {8{16'h8000}}) begin bad++; $display("FAIL wrap_add got=%h want=%h", r2, {8{16'h8000}}); end
    for (int i = 0; i < 8; i++) begin
      a2[i*16 +: 16] = -16'sd200;
      b2[i*16 +: 16] = 16'd300;
    end
    op2 = 3'b001; se2 = 1;
    go(1, lat);
    cmp++; if (lat !== 9) begin bad++; $display("FAIL mul_latency got=%0d want=9", lat); end
    cmp++; if (r2 !== {8{16'h8000}}) begin bad++; $display("FAIL sat_mul got=%h want=%h", r2, {8{16'h8000}}); end
    se2 = 0;
    go(1, lat);
    cmp++; if (r2 !== {8{16'h15A0}}) begin bad++; $display("FAIL wrap_mul got=%h want=%h", r2, {8{16'h15A0}}); end
  endtask

  task automatic test_fir;
    int lat;
    int y[8] = '{1, 4, 10, 20, 30, 40, 50, 60};
    a1 = 0; b1 = 0; e1 = 0;
    for (int i = 0; i < 8; i++) a1[i*32 +: 32] = i < 4 ? i + 1 : 99;
    b1[31:0] = 1;
    for (int i = 0; i < 4; i++) e1[i*32 +: 32] = i + 1;
    op1 = 3'b010; se1 = 0;
    go(0, lat);
    cmp++; if (lat !== 33) begin bad++; $display("FAIL fir_latency got=%0d want=33", lat); end
    cmp++; if (r1 !== e1) begin bad++; $display("FAIL fir_impulse got=%h want=%h", r1, e1); end
    for (int i = 0; i < 8; i++) begin
      b1[i*32 +: 32] = i + 1;
      e1[i*32 +: 32] = y[i];
    end
    go(0, lat);
    cmp++; if (r1 !== e1) begin bad++; $display("FAIL fir_ramp got=%h want=%h", r1, e1); end
  endtask

  task automatic test_dot;
    int lat;
    for (int i = 0; i < 8; i++) begin
      a1[i*32 +: 32] = 3;
      b1[i*32 +: 32] = i + 1;
    end
    e1 = 0; e1[31:0] = 108;
    op1 = 3'b100; se1 = 0;
    go(0, lat);
    cmp++; if (lat !== 9) begin bad++; $display("FAIL dot_latency got=%0d want=9", lat); end
    cmp++; if (r1 !== e1) begin bad++; $display("FAIL dot_result got=%h want=%h", r1, e1); end
  endtask

  task automatic test_handshake;
    int lat;
    for (int i = 0; i < 8; i++) begin
      a1[i*32 +: 32] = i + 1;
      b1[i*32 +: 32] = 10 * (i + 1);
      e1[i*32 +: 32] = 11 * (i + 1);
    end
    op1 = 3'b000; se1 = 0;
    @(negedge clk);
    s1 = 1;
    @(negedge clk);
    s1 = 0; lat = 1;
    cmp++; if (by1 !== 1) begin bad++; $display("FAIL busy_after_start got=%b want=1", by1); end
    while (!dn1 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin a1 = '1; b1 = '1; op1 = 3'b001; s1 = 1; se1 = 1; end
      if (lat == 5) s1 = 0;
    end
    cmp++; if (lat !== 9) begin bad++; $display("FAIL midexec_latency got=%0d want=9", lat); end
    cmp++; if (r1 !== e1) begin bad++; $display("FAIL midexec_result got=%h want=%h", r1, e1); end
    cmp++; if (by1 !== 0) begin bad++; $display("FAIL busy_in_done got=%b want=0", by1); end
    @(negedge clk);
    cmp++; if (dn1 !== 0 || by1 !== 0) begin bad++; $display("FAIL done_pulse got=%b%b want=00", dn1, by1); end
    cmp++; if (r1 !== e1) begin bad++; $display("FAIL result_hold got=%h want=%h", r1, e1); end
    op1 = 3'b101;
    go(0, lat);
    cmp++; if (lat !== 2) begin bad++; $display("FAIL illegal_latency got=%0d want=2", lat); end
    cmp++; if (r1 !== 0) begin bad++; $display("FAIL illegal_result got=%h want=0", r1); end
    op1 = 3'b000; se1 = 0;
    for (int i = 0; i < 8; i++) begin
      a1[i*32 +: 32] = i + 1;
      b1[i*32 +: 32] = 10 * (i + 1);
    end
    @(negedge clk);
    s1 = 1;
    lat = 0;
    while (!dn1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    cmp++; if (by1 !== 0) begin bad++; $display("FAIL start_in_done got=%b want=0", by1); end
    @(negedge clk);
    s1 = 0;
    cmp++; if (by1 !== 1) begin bad++; $display("FAIL start_after_done got=%b want=1", by1); end
    lat = 1;
    while (!dn1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    cmp++; if (lat !== 9 || r1 !== e1) begin bad++; $display("FAIL held_start_op got lat=%0d res=%h want lat=9 res=%h", lat, r1, e1); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen = 0;
    for (int i = 0; i < 8; i++) begin
      a1[i*32 +: 32] = i + 1;
      b1[i*32 +: 32] = i + 1;
    end
    op1 = 3'b010;
    @(negedge clk);
    s1 = 1;
    @(negedge clk);
    s1 = 0;
    repeat (9) @(negedge clk);
    rst = 1;
    #1;
    cmp++; if (r1 !== 0) begin bad++; $display("FAIL midreset_result got=%h want=0", r1); end
    cmp++; if (by1 !== 0 || dn1 !== 0) begin bad++; $display("FAIL midreset_flags got=%b%b want=00", by1, dn1); end
    @(negedge clk);
    rst = 0;
    repeat (40) begin
      @(negedge clk);
      if (dn1) seen = 1;
    end
    cmp++; if (seen !== 0) begin bad++; $display("FAIL midreset_no_done got=%b want=0", seen); end
    for (int i = 0; i < 8; i++) begin
      a1[i*32 +: 32] = 3;
      b1[i*32 +: 32] = i + 1;
    end
    e1 = 0; e1[31:0] = 108;
    op1 = 3'b100;
    go(0, lat);
    cmp++; if (lat !== 9 || r1 !== e1) begin bad++; $display("FAIL post_reset_dot got lat=%0d res=%h want lat=9 res=%h", lat, r1, e1); end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_sat;
    test_fir;
    test_dot;
    test_handshake;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
